// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_ctrl
// Description : 4-digit common-anode 7-segment scan controller for the
//               stopwatch. It shows sec.msec when sw=0 and hour.min when
//               sw=1. The time fields and sw are captured once per frame,
//               so a frame always shows one consistent time value.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_HZ   - input clock frequency
//   SCAN_HZ  - per-digit refresh rate (CLK_HZ/SCAN_HZ must be >= 2)
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous reset, active low
//   sw       in   1  display mode: 0 = sec.msec, 1 = hour.min
//   msec     in   7  hundredths of a second (0..99)
//   sec      in   6  seconds (0..59)
//   min      in   6  minutes (0..59)
//   hour     in   5  hours (0..23)
//   fnd_com  out  4  digit enables, active-low one-hot, bit0 = rightmost
//   fnd_data out  8  segments, active low, {dp,g,f,e,d,c,b,a}
// ============================================================================
module fnd_scan_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_DASH = 7'h3F;  // only segment g lit

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Inputs are at most 127, so a quotient of 12 still fits 4 bits.
    // Out-of-range fields are replaced by dashes before their digits are used.
    function automatic logic [3:0] ones_of(input logic [6:0] v);
        ones_of = 4'(v % 7'd10);
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        tens_of = 4'(v / 7'd10);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [1:0]       sel_q,  sel_d;
    logic [6:0]       msec_q, msec_d;
    logic [5:0]       sec_q,  sec_d;
    logic [5:0]       min_q,  min_d;
    logic [4:0]       hour_q, hour_d;
    logic             mode_q, mode_d;
    logic [3:0]       com_q,  com_d;
    logic [7:0]       data_q, data_d;

    logic             scan_tick;
    logic             frame_end;
    logic [6:0]       lo_val, hi_val;
    logic             lo_ok,  hi_ok;
    logic [3:0]       digit_val;
    logic             digit_ok;
    logic [6:0]       seg_bits;
    logic             dp_n;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        scan_tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d     = scan_tick ? '0 : cnt_q + CNT_W'(1);
        sel_d     = scan_tick ? sel_q + 2'd1 : sel_q;

        // The snapshot changes on the same edge that moves from digit3 to
        // digit0. The output register still samples digit3 from the old
        // snapshot on that edge, so no frame mixes old and new values.
        frame_end = scan_tick && (sel_q == 2'd3);
        msec_d    = frame_end ? msec : msec_q;
        sec_d     = frame_end ? sec  : sec_q;
        min_d     = frame_end ? min  : min_q;
        hour_d    = frame_end ? hour : hour_q;
        mode_d    = frame_end ? sw   : mode_q;

        // Digits 0/1 come from the low field and digits 2/3 from the high
        // field. Each field is shown as two decimal digits.
        if (mode_q) begin
            lo_val = {1'b0, min_q};
            lo_ok  = (min_q <= 6'd59);
            hi_val = {2'b00, hour_q};
            hi_ok  = (hour_q <= 5'd23);
        end else begin
            lo_val = msec_q;
            lo_ok  = (msec_q <= 7'd99);
            hi_val = {1'b0, sec_q};
            hi_ok  = (sec_q <= 6'd59);
        end

        case (sel_q)
            2'd0:    begin digit_val = ones_of(lo_val); digit_ok = lo_ok; end
            2'd1:    begin digit_val = tens_of(lo_val); digit_ok = lo_ok; end
            2'd2:    begin digit_val = ones_of(hi_val); digit_ok = hi_ok; end
            default: begin digit_val = tens_of(hi_val); digit_ok = hi_ok; end
        endcase

        seg_bits = digit_ok ? seg7(digit_val) : SEG_DASH;

        // The dp on digit2 follows the first half of each second in both
        // modes, which gives a 1 Hz blink.
        dp_n = !((sel_q == 2'd2) && (msec_q < 7'd50));

        com_d  = ~(4'b0001 << sel_q);
        data_d = {dp_n, seg_bits};
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sel_q  <= 2'd0;
            msec_q <= 7'd0;
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hour_q <= 5'd0;
            mode_q <= 1'b0;
            com_q  <= 4'b1111;
            data_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            mode_q <= mode_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule
`default_nettype wire
